blockmem_zeroize: RTL

BLOCKMEM_ZEROIZE -- requirements
Module: blockmem_zeroize

---
 rtl/blockmem_zeroize.sv | 121 ++++++++++++
 1 files changed

// File: rtl/blockmem_zeroize.sv
// blockmem_zeroize: DEPTH x DATA_WIDTH memory with one registered read port,
// one byte-masked write port and a zeroize controller that sweeps every word
// to zero, either on request or automatically after reset.
module blockmem_zeroize #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int ZERO_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    zeroize,
    output logic                    busy,
    input  logic                    read_en,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    input  logic                    wr,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_mask
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (ZERO_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic   RST_BUSY  = (ZERO_ON_RESET != 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
            $error("blockmem_zeroize: DATA_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] wbits;

    // Expand the per-byte write mask to a per-bit mask.
    genvar gb;
    generate
        for (gb = 0; gb < NBYTES; gb++) begin : g_wbits
            assign wbits[8*gb +: 8] = {8{write_mask[gb]}};
        end
    endgenerate

    // Controller next state and read path; the read samples the array before
    // any same-edge write lands, giving read-first behaviour.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_en) begin
                    rdata_d  = mem[read_addr];
                    rvalid_d = 1'b1;
                end
                if (zeroize) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                // Leave on the last address instead of letting the counter wrap.
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Controller and read-port registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            busy_q   <= RST_BUSY;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage array: sweep writes zero, otherwise the masked write port.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (wr) begin
            mem[write_addr] <= (mem[write_addr] & ~wbits) | (write_data & wbits);
        end
    end

    assign busy       = busy_q;
    assign read_data  = rdata_q;
    assign read_valid = rvalid_q;

endmodule
